histogram_engine: RTL

HISTOGRAM_ENGINE -- requirements
Module: histogram_engine

---
 rtl/histogram_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/histogram_engine.sv
// Histogram engine: 3-stage RMW bin counter with S2->S1 forwarding; host reads return 2 cycles after rd_en.
// Backpressure: in_ready low during the clear sweep and in the clear_in cycle; reads are never stalled.
module histogram_engine #(
    parameter int NUM_BINS    = 256,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_in_n,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        clear_in,
    input  logic                        rd_en,
    input  logic [$clog2(NUM_BINS)-1:0] rd_addr,
    output logic                        rd_valid,
    output logic [COUNT_WIDTH-1:0]      rd_data,
    output logic [31:0]                 total_count,
    output logic [$clog2(NUM_BINS)-1:0] mode_bin,
    output logic [COUNT_WIDTH-1:0]      mode_count,
    output logic                        busy
);
    localparam int AW = $clog2(NUM_BINS);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [AW-1:0]          LAST_BIN = AW'(NUM_BINS - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                 state;
    logic [AW-1:0]          clr_addr;

    // Two identical single-read/single-write RAMs: one serves the update pipeline, one the host read port.
    logic [COUNT_WIDTH-1:0] upd_mem [NUM_BINS];
    logic [COUNT_WIDTH-1:0] rd_mem  [NUM_BINS];

    logic                   accept;
    logic                   rd_go;
    logic                   run_clear;

    logic                   s1_vld;
    logic [AW-1:0]          s1_bin;
    logic                   s2_vld;
    logic [AW-1:0]          s2_bin;
    logic [COUNT_WIDTH-1:0] s2_ram;
    logic                   s2_fwd;
    logic [COUNT_WIDTH-1:0] s2_fwd_val;
    logic [COUNT_WIDTH-1:0] s2_base;
    logic [COUNT_WIDTH-1:0] s2_new;

    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [COUNT_WIDTH-1:0] wr_data;

    logic                   rd1_vld;
    logic [AW-1:0]          rd1_addr;
    logic [COUNT_WIDTH-1:0] rd1_ram;
    logic                   rd1_fwd;
    logic [COUNT_WIDTH-1:0] rd1_fwd_val;

    assign busy      = (state == CLEAR);
    assign run_clear = (state == RUN) && clear_in;
    assign in_ready  = (state == RUN) && !clear_in;
    assign accept    = in_valid && in_ready;
    assign rd_go     = rd_en && (state == RUN);

    assign s2_base = s2_fwd ? s2_fwd_val : s2_ram;
    assign s2_new  = (s2_base == CNT_MAX) ? s2_base : s2_base + COUNT_WIDTH'(1);

    // Single write port shared by the clear sweep and the S2 update; nothing is written during reset.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s2_bin;
        wr_data = s2_new;
        if (rst_in_n) begin
            if (state == CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = clr_addr;
                wr_data = '0;
            end else begin
                wr_en = s2_vld && !clear_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            upd_mem[wr_addr] <= wr_data;
        end
        s2_ram <= upd_mem[s1_bin];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rd_mem[wr_addr] <= wr_data;
        end
        rd1_ram <= rd_mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_in_n) begin
            state       <= CLEAR;
            clr_addr    <= '0;
            s1_vld      <= 1'b0;
            s1_bin      <= '0;
            s2_vld      <= 1'b0;
            s2_bin      <= '0;
            s2_fwd      <= 1'b0;
            s2_fwd_val  <= '0;
            rd1_vld     <= 1'b0;
            rd1_addr    <= '0;
            rd1_fwd     <= 1'b0;
            rd1_fwd_val <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            total_count <= '0;
            mode_bin    <= '0;
            mode_count  <= '0;
        end else begin
            s1_vld     <= accept;
            s1_bin     <= in_data[AW-1:0];
            s2_vld     <= s1_vld && !run_clear;
            s2_bin     <= s1_bin;
            // The RAM returns pre-write data when read and written at the same edge, so capture the write.
            s2_fwd     <= wr_en && (wr_addr == s1_bin);
            s2_fwd_val <= wr_data;

            rd1_vld     <= rd_go;
            rd1_addr    <= rd_addr;
            rd1_fwd     <= wr_en && (wr_addr == rd_addr);
            rd1_fwd_val <= wr_data;
            rd_valid    <= rd1_vld;
            if (rd1_vld) begin
                if (wr_en && (wr_addr == rd1_addr)) begin
                    rd_data <= wr_data;
                end else if (rd1_fwd) begin
                    rd_data <= rd1_fwd_val;
                end else begin
                    rd_data <= rd1_ram;
                end
            end

            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == LAST_BIN) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (clear_in) begin
                        state       <= CLEAR;
                        clr_addr    <= '0;
                        total_count <= '0;
                        mode_bin    <= '0;
                        mode_count  <= '0;
                    end else begin
                        if (accept && (total_count != 32'hFFFF_FFFF)) begin
                            total_count <= total_count + 32'd1;
                        end
                        // Strict compare keeps the earlier bin on a tie.
                        if (wr_en && (s2_new > mode_count)) begin
                            mode_bin   <= s2_bin;
                            mode_count <= s2_new;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
